sugar_placer: RTL and testbench
===============================

SUGAR_PLACER -- requirements
Module: sugar_placer

Interface
REQ-001 The block SHALL have parameter NUM_PATCHES, default 4, giving the number of sugar patches it programs.
REQ-002 The block SHALL have parameter START_X, default X_MAX/2, giving the cursor X position after reset and after start.
REQ-003 The block SHALL have parameter START_Y, default Y_MAX/2, giving the cursor Y position after reset and after start.
REQ-004 The block SHALL have parameter LFSR_SEED, default 16'hACE1, giving the auto-placement seed.
REQ-005 setup_clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 RESET  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle pulse that begins a placement session.
REQ-008 move_up, move_down, move_left, move_right  in  1 each  one-cycle cursor step requests.
REQ-009 place  in  1  one-cycle request to commit a patch at the cursor.
REQ-010 finish  in  1  one-cycle request to end the session early.
REQ-011 patch_collision  in  NUM_PATCHES  per-patch collision flags, driven by patches whose collide_x/collide_y inputs are driven from out_x/out_y.
REQ-012 SETUP_PHASE  out  1  setup phase qualifier to all patches.
REQ-013 SET  out  NUM_PATCHES  one-hot load strobe, bit i to patch i.
REQ-014 out_x  out  X_bits  cursor X, feeding patch in_x and collide_x.
REQ-015 out_y  out  Y_bits  cursor Y, feeding patch in_y and collide_y.
REQ-016 patch_count  out  $clog2(NUM_PATCHES+1)  number of patches placed.
REQ-017 reject  out  1  one-cycle pulse when a place request is refused.
REQ-018 done  out  1  high once the session has ended.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, SETUP, COMMIT and DONE.
REQ-020 IDLE SHALL go to SETUP on start, load the cursor with START_X/START_Y and clear patch_count.
REQ-021 In SETUP, each move pulse SHALL step the cursor by 1, saturating at 0 and at X_MAX/Y_MAX.
REQ-022 In SETUP, opposing move pulses in the same cycle SHALL cancel on that axis.
REQ-023 In SETUP, place with |patch_collision == 0 SHALL go to COMMIT on the next edge; move pulses in that cycle SHALL be ignored.
REQ-024 In SETUP, place with |patch_collision == 1 SHALL pulse reject for exactly one cycle (the following cycle) and stay in SETUP with the cursor unchanged.
REQ-025 COMMIT SHALL last exactly one cycle, during which SET[patch_count] = 1 and all other SET bits = 0; out_x/out_y SHALL hold steady.
REQ-026 Leaving COMMIT, patch_count SHALL increment; the next state SHALL be DONE if the new count equals NUM_PATCHES, otherwise SETUP.
REQ-027 Latency: place sampled at edge n SHALL produce SET high during cycle n+1, with patch_count updated at edge n+2.
REQ-028 finish in SETUP SHALL go to DONE; finish asserted together with place SHALL take priority, so no commit occurs.
REQ-029 Inputs other than start SHALL be ignored in IDLE, COMMIT and DONE.
REQ-030 DONE SHALL hold done = 1 and SETUP_PHASE = 0 until RESET.
REQ-031 start in DONE SHALL be ignored; only RESET re-arms the block.
REQ-032 SETUP_PHASE SHALL be 1 exactly in the SETUP and COMMIT states.
REQ-033 SET SHALL never have more than one bit high.
REQ-034 SET SHALL never be high outside COMMIT.

Reset
REQ-035 RESET SHALL force the state to IDLE, SET = 0, SETUP_PHASE = 0, reject = 0, done = 0, patch_count = 0 and out_x/out_y = START_X/START_Y on the next edge.
REQ-036 The reset values in REQ-035 SHALL apply regardless of the current state, including COMMIT.
REQ-037 RESET SHALL reload the LFSR with LFSR_SEED.

Configuration
REQ-038 With SUGAR_AUTO_PLACE_EN defined, the SETUP state SHALL load the cursor each cycle from the LFSR (x = lfsr[X_bits-1:0], y = lfsr[15 -: Y_bits]).
REQ-039 With SUGAR_AUTO_PLACE_EN defined, an implicit place SHALL be raised one cycle after each load.
REQ-040 With SUGAR_AUTO_PLACE_EN defined, candidates that are out of range or colliding SHALL be silently skipped (no reject pulse), and move/place inputs SHALL be ignored.
REQ-041 Without SUGAR_AUTO_PLACE_EN, placement SHALL be manual only, and neither the LFSR nor auto-placement logic SHALL be present.

Structure
REQ-042 X_bits, Y_bits, X_MAX, Y_MAX, SUGARPATCH_RADIUS and the FSM state enum SHALL live in the shared params package.
REQ-043 The LFSR SHALL be sub-module lfsr16, Fibonacci form with taps 16,14,13,11, advancing every cycle while enabled.

Verification
REQ-044 Reset, start, 3 x move_right, 2 x move_up, place -> COMMIT with SET = 4'b0001, out_x = START_X+3, out_y = START_Y-2 (up decrements Y), then patch_count = 1.
REQ-045 Cursor at X = X_MAX, move_right -> out_x stays X_MAX; cursor at 0, move_left -> out_x stays 0.
REQ-046 Place with patch_collision = 4'b0010 -> reject high for one cycle, SET stays 0, patch_count unchanged.
REQ-047 Four successful places -> SET strobes 0001, 0010, 0100, 1000 in order, then done = 1, SETUP_PHASE = 0, and further place is ignored.
REQ-048 place and finish in the same cycle -> DONE, no SET pulse, patch_count unchanged.
REQ-049 RESET asserted during COMMIT -> next cycle SET = 0, state IDLE, patch_count = 0, cursor = START.

Source files
------------

// File: rtl/sugar_placer_pkg.sv
// Shared playfield geometry and FSM state encoding for the sugar placer.
package sugar_placer_pkg;

    // Playfield geometry, in patch-grid units.
    localparam int unsigned X_bits            = 8;
    localparam int unsigned Y_bits            = 7;
    localparam int unsigned X_MAX             = 159;
    localparam int unsigned Y_MAX             = 119;
    localparam int unsigned SUGARPATCH_RADIUS = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        COMMIT,
        DONE
    } state_t;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11. Shifts left with feedback in bit 0.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [15:0] value
);

    logic [15:0] lfsr_q;
    logic        feedback;

    assign feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign value    = lfsr_q;

    // Reload the seed on reset, otherwise advance once per enabled cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else if (enable) begin
            lfsr_q <= {lfsr_q[14:0], feedback};
        end
    end

endmodule

// File: rtl/sugar_placer.sv
// Sugar patch placer: steers a cursor over the playfield and strobes one patch
// load per commit. Define SUGAR_AUTO_PLACE_EN to let an LFSR pick the positions
// instead of the move/place buttons.
module sugar_placer
    import sugar_placer_pkg::*;
#(
    parameter int unsigned NUM_PATCHES = 4,
    parameter int unsigned START_X     = X_MAX / 2,
    parameter int unsigned START_Y     = Y_MAX / 2,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                               setup_clk,
    input  logic                               RESET,
    input  logic                               start,
    input  logic                               move_up,
    input  logic                               move_down,
    input  logic                               move_left,
    input  logic                               move_right,
    input  logic                               place,
    input  logic                               finish,
    input  logic [NUM_PATCHES-1:0]             patch_collision,
    output logic                               SETUP_PHASE,
    output logic [NUM_PATCHES-1:0]             SET,
    output logic [X_bits-1:0]                  out_x,
    output logic [Y_bits-1:0]                  out_y,
    output logic [$clog2(NUM_PATCHES+1)-1:0]   patch_count,
    output logic                               reject,
    output logic                               done
);

    localparam int unsigned CW = $clog2(NUM_PATCHES + 1);

    localparam logic [X_bits-1:0]      X_LIM   = X_bits'(X_MAX);
    localparam logic [Y_bits-1:0]      Y_LIM   = Y_bits'(Y_MAX);
    localparam logic [X_bits-1:0]      X_START = X_bits'(START_X);
    localparam logic [Y_bits-1:0]      Y_START = Y_bits'(START_Y);
    localparam logic [NUM_PATCHES-1:0] SET_ONE = NUM_PATCHES'(1);

    // An all-zero seed would lock the LFSR at zero forever.
    if (LFSR_SEED == 16'h0000) begin : g_seed_check
        $error("LFSR_SEED must be nonzero");
    end

    state_t            state_q, state_d;
    logic [X_bits-1:0] x_q, x_d;
    logic [Y_bits-1:0] y_q, y_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     count_inc;
    logic              reject_q, reject_d;
    logic              collide;

    assign collide   = |patch_collision;
    assign count_inc = count_q + CW'(1);

`ifdef SUGAR_AUTO_PLACE_EN
    logic        pending_q, pending_d;
    logic [15:0] lfsr_value;
    logic        cand_oob;
    logic        unused_manual;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr16 (
        .clk    (setup_clk),
        .reset  (RESET),
        .enable (state_q == SETUP),
        .value  (lfsr_value)
    );

    assign cand_oob      = (x_q > X_LIM) || (y_q > Y_LIM);
    assign unused_manual = ^{move_up, move_down, move_left, move_right, place, lfsr_value};

    // A candidate is pending once it has sat in the cursor for one cycle.
    always_ff @(posedge setup_clk) begin
        if (RESET) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end
`else
    logic [X_bits-1:0] step_x;
    logic [Y_bits-1:0] step_y;

    // Saturating cursor step; opposing pulses on one axis cancel. Up decrements Y.
    always_comb begin
        step_x = x_q;
        step_y = y_q;
        if (move_right && !move_left && x_q != X_LIM) begin
            step_x = x_q + X_bits'(1);
        end else if (move_left && !move_right && x_q != '0) begin
            step_x = x_q - X_bits'(1);
        end
        if (move_down && !move_up && y_q != Y_LIM) begin
            step_y = y_q + Y_bits'(1);
        end else if (move_up && !move_down && y_q != '0) begin
            step_y = y_q - Y_bits'(1);
        end
    end
`endif

    // State, cursor, count and reject registers.
    always_ff @(posedge setup_clk) begin
        if (RESET) begin
            state_q  <= IDLE;
            x_q      <= X_START;
            y_q      <= Y_START;
            count_q  <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            count_q  <= count_d;
            reject_q <= reject_d;
        end
    end

    // Next-state logic; finish always wins over a same-cycle place.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        count_d  = count_q;
        reject_d = 1'b0;
`ifdef SUGAR_AUTO_PLACE_EN
        pending_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                    x_d     = X_START;
                    y_d     = Y_START;
                    count_d = '0;
                end
            end
            SETUP: begin
                if (finish) begin
                    state_d = DONE;
`ifdef SUGAR_AUTO_PLACE_EN
                end else if (pending_q && !cand_oob && !collide) begin
                    state_d = COMMIT;
                end else begin
                    // Bad or first candidate: silently draw a fresh one.
                    x_d       = lfsr_value[X_bits-1:0];
                    y_d       = lfsr_value[15 -: Y_bits];
                    pending_d = 1'b1;
                end
`else
                end else if (place) begin
                    if (collide) begin
                        reject_d = 1'b1;
                    end else begin
                        state_d = COMMIT;
                    end
                end else begin
                    x_d = step_x;
                    y_d = step_y;
                end
`endif
            end
            COMMIT: begin
                count_d = count_inc;
                state_d = (count_inc == CW'(NUM_PATCHES)) ? DONE : SETUP;
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Load strobe: exactly the next free patch, only while committing.
    always_comb begin
        SET = '0;
        if (state_q == COMMIT) begin
            SET = SET_ONE << count_q;
        end
    end

    assign SETUP_PHASE = (state_q == SETUP) || (state_q == COMMIT);
    assign done        = (state_q == DONE);
    assign reject      = reject_q;
    assign out_x       = x_q;
    assign out_y       = y_q;
    assign patch_count = count_q;

endmodule

// File: tb/tb_sugar_placer.sv
// Self-checking bench for sugar_placer (manual placement build).
module tb_sugar_placer;
    import sugar_placer_pkg::*;

    localparam int NP = 4;
    localparam int SX = X_MAX / 2;
    localparam int SY = Y_MAX / 2;

    logic              clk = 1'b0;
    logic              RESET = 1'b1;
    logic              start = 1'b0;
    logic              move_up = 1'b0;
    logic              move_down = 1'b0;
    logic              move_left = 1'b0;
    logic              move_right = 1'b0;
    logic              place = 1'b0;
    logic              finish = 1'b0;
    logic [NP-1:0]     patch_collision = '0;
    logic              SETUP_PHASE;
    logic [NP-1:0]     SET;
    logic [X_bits-1:0] out_x;
    logic [Y_bits-1:0] out_y;
    logic [2:0]        patch_count;
    logic              reject;
    logic              done;

    int checks = 0;
    int failures = 0;
    int mx, my, mcnt;

    always #5 clk = ~clk;

    sugar_placer dut (
        .setup_clk       (clk),
        .RESET           (RESET),
        .start           (start),
        .move_up         (move_up),
        .move_down       (move_down),
        .move_left       (move_left),
        .move_right      (move_right),
        .place           (place),
        .finish          (finish),
        .patch_collision (patch_collision),
        .SETUP_PHASE     (SETUP_PHASE),
        .SET             (SET),
        .out_x           (out_x),
        .out_y           (out_y),
        .patch_count     (patch_count),
        .reject          (reject),
        .done            (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 ns after the edge.
    task automatic drive(input logic u, input logic d, input logic l, input logic r,
                         input logic p, input logic f, input logic s,
                         input logic [NP-1:0] c);
        move_up = u; move_down = d; move_left = l; move_right = r;
        place = p; finish = f; start = s; patch_collision = c;
        @(posedge clk);
        #1;
        move_up = 0; move_down = 0; move_left = 0; move_right = 0;
        place = 0; finish = 0; start = 0; patch_collision = '0;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, '0);
    endtask

    // Reference cursor: clamp the signed net step into [0, MAX]; up means smaller Y.
    task automatic model_move(input logic u, input logic d, input logic l, input logic r);
        int dx, dy;
        dx = int'(r) - int'(l);
        dy = int'(d) - int'(u);
        mx = mx + dx;
        my = my + dy;
        if (mx < 0) mx = 0;
        if (mx > X_MAX) mx = X_MAX;
        if (my < 0) my = 0;
        if (my > Y_MAX) my = Y_MAX;
    endtask

    task automatic move(input logic u, input logic d, input logic l, input logic r);
        drive(u, d, l, r, 0, 0, 0, '0);
        model_move(u, d, l, r);
    endtask

    task automatic chk_cursor(input string tag);
        chk({tag, "_x"}, 32'(out_x), mx);
        chk({tag, "_y"}, 32'(out_y), my);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_set"}, 32'(SET), 0);
        chk({tag, "_phase"}, 32'(SETUP_PHASE), 0);
        chk({tag, "_reject"}, 32'(reject), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_count"}, 32'(patch_count), 0);
        chk({tag, "_x"}, 32'(out_x), SX);
        chk({tag, "_y"}, 32'(out_y), SY);
    endtask

    // Global time bound so the bench can never hang.
    initial begin
        #1000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end

    initial begin
        logic u, d, l, r;
        logic [NP-1:0] c;

        // Reset and idle behaviour.
        RESET = 1'b1;
        idle();
        idle();
        chk_reset_state("reset");
        RESET = 1'b0;
        idle();
        drive(0, 0, 0, 1, 1, 0, 0, '0);
        chk_reset_state("idle_ignores");

        // Start, then the directed 3 right / 2 up / place walk.
        drive(0, 0, 0, 0, 0, 0, 1, '0);
        mx = SX; my = SY; mcnt = 0;
        chk("start_phase", 32'(SETUP_PHASE), 1);
        chk_cursor("start");
        repeat (3) move(0, 0, 0, 1);
        repeat (2) move(1, 0, 0, 0);
        chk_cursor("walk");
        drive(0, 0, 0, 0, 1, 0, 0, '0);
        chk("first_set", 32'(SET), 1);
        chk("first_x", 32'(out_x), SX + 3);
        chk("first_y", 32'(out_y), SY - 2);
        chk("commit_count_old", 32'(patch_count), 0);
        idle();
        mcnt = 1;
        chk("first_count", 32'(patch_count), mcnt);
        chk("first_set_clear", 32'(SET), 0);
        chk("first_back_setup", 32'(SETUP_PHASE), 1);

        // Saturation at both X edges and the top Y edge.
        repeat (100) move(0, 0, 0, 1);
        chk("x_sat_max", 32'(out_x), X_MAX);
        move(0, 0, 0, 1);
        chk("x_stays_max", 32'(out_x), X_MAX);
        repeat (170) move(0, 0, 1, 0);
        chk("x_sat_zero", 32'(out_x), 0);
        move(0, 0, 1, 0);
        chk("x_stays_zero", 32'(out_x), 0);
        repeat (70) move(1, 0, 0, 0);
        chk("y_sat_zero", 32'(out_y), 0);

        // Randomised moves, including same-cycle opposing pulses.
        for (int i = 0; i < 60; i++) begin
            u = 1'($urandom); d = 1'($urandom); l = 1'($urandom); r = 1'($urandom);
            move(u, d, l, r);
            chk_cursor("rand_move");
            chk("rand_move_set", 32'(SET), 0);
        end

        // Collided places are refused for exactly one cycle; moves that cycle are ignored.
        drive(0, 0, 0, 0, 1, 0, 0, 4'b0010);
        chk("reject_pulse", 32'(reject), 1);
        chk("reject_set", 32'(SET), 0);
        chk_cursor("reject_cursor");
        idle();
        chk("reject_drop", 32'(reject), 0);
        chk("reject_count", 32'(patch_count), mcnt);
        for (int i = 0; i < 6; i++) begin
            c = NP'($urandom_range(1, (1 << NP) - 1));
            u = 1'($urandom); d = 1'($urandom); l = 1'($urandom); r = 1'($urandom);
            drive(u, d, l, r, 1, 0, 0, c);
            chk("rand_reject", 32'(reject), 1);
            chk("rand_reject_phase", 32'(SETUP_PHASE), 1);
            chk_cursor("rand_reject_cursor");
            idle();
            chk("rand_reject_once", 32'(reject), 0);
            chk("rand_reject_set", 32'(SET), 0);
        end

        // Remaining places strobe SET in order, then the session ends.
        while (mcnt < NP) begin
            u = 1'($urandom); d = 1'($urandom); l = 1'($urandom); r = 1'($urandom);
            drive(u, d, l, r, 1, 0, 0, '0);
            chk("seq_set", 32'(SET), 1 << mcnt);
            chk("seq_phase", 32'(SETUP_PHASE), 1);
            chk_cursor("seq_cursor_hold");
            idle();
            mcnt++;
            chk("seq_count", 32'(patch_count), mcnt);
            chk("seq_set_clear", 32'(SET), 0);
        end
        chk("full_done", 32'(done), 1);
        chk("full_phase", 32'(SETUP_PHASE), 0);
        drive(0, 0, 0, 0, 1, 0, 0, '0);
        chk("done_place_set", 32'(SET), 0);
        chk("done_place_count", 32'(patch_count), NP);
        drive(0, 0, 0, 0, 0, 0, 1, '0);
        chk("done_start_ignored", 32'(done), 1);
        chk("done_start_phase", 32'(SETUP_PHASE), 0);

        // place together with finish: finish wins, nothing commits.
        RESET = 1'b1;
        idle();
        RESET = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 1, '0);
        mx = SX; my = SY;
        move(0, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 1, 0, '0);
        chk("pf_done", 32'(done), 1);
        chk("pf_set", 32'(SET), 0);
        chk("pf_count", 32'(patch_count), 0);
        chk("pf_reject", 32'(reject), 0);
        idle();
        chk("pf_set_later", 32'(SET), 0);
        chk("pf_count_later", 32'(patch_count), 0);

        // Reset landing in the middle of COMMIT.
        RESET = 1'b1;
        idle();
        RESET = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 1, '0);
        move(0, 1, 1, 0);
        drive(0, 0, 0, 0, 1, 0, 0, '0);
        chk("rc_in_commit", 32'(SET), 1);
        RESET = 1'b1;
        idle();
        chk_reset_state("rc");
        RESET = 1'b0;
        drive(0, 0, 0, 1, 0, 0, 0, '0);
        chk("rc_idle_phase", 32'(SETUP_PHASE), 0);
        chk("rc_idle_x", 32'(out_x), SX);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
